// File: rtl/red_pitaya_clk_gen_if.sv
// Configuration and output bundle for red_pitaya_clk_gen.
//
// The housekeeping register bank drives the config side (master); the clock generator consumes it
// (slave).
//   en_i      per-channel enable, level
//   period_i  per-channel period P, channel n at [n*CW +: CW]
//   high_i    per-channel high time H
//   phase_i   per-channel start count F
//   sync_i    one-cycle pulse, restarts all running channels at their phase
//   clk_o     divided clock outputs
//   tick_o    one-cycle strobe at each period start
//   run_o     channel is running
//   edges_o   per-channel tick count (only with RED_PITAYA_CLK_GEN_EDGE_CNT_EN)
interface red_pitaya_clk_gen_if #(
  parameter int unsigned CHN = 4,
  parameter int unsigned CW  = 32
);

  logic [CHN-1:0]    en_i;
  logic [CHN*CW-1:0] period_i;
  logic [CHN*CW-1:0] high_i;
  logic [CHN*CW-1:0] phase_i;
  logic              sync_i;
  logic [CHN-1:0]    clk_o;
  logic [CHN-1:0]    tick_o;
  logic [CHN-1:0]    run_o;
`ifdef RED_PITAYA_CLK_GEN_EDGE_CNT_EN
  logic [CHN*CW-1:0] edges_o;
`endif

  modport master (
    output en_i,
    output period_i,
    output high_i,
    output phase_i,
    output sync_i,
    input  clk_o,
    input  tick_o,
`ifdef RED_PITAYA_CLK_GEN_EDGE_CNT_EN
    input  edges_o,
`endif
    input  run_o
  );

  modport slave (
    input  en_i,
    input  period_i,
    input  high_i,
    input  phase_i,
    input  sync_i,
    output clk_o,
    output tick_o,
`ifdef RED_PITAYA_CLK_GEN_EDGE_CNT_EN
    output edges_o,
`endif
    output run_o
  );

endinterface

// File: rtl/red_pitaya_clk_gen.sv
// Multi-channel programmable clock/strobe generator.
//
// CHN independent channels, each dividing clk_i by a run-time period P with high time H and start
// count F. A global sync pulse restarts every running channel at its phase so that channels with
// equal P and F run cycle-aligned. All outputs are registered.
//
// Ports:
//   clk_i  system clock
//   rst_i  synchronous reset, active-high, dominates everything
//   cfg    red_pitaya_clk_gen_if slave: en_i, period_i, high_i, phase_i, sync_i in;
//          clk_o, tick_o, run_o (and edges_o) out
//
// Optional feature, macro RED_PITAYA_CLK_GEN_EDGE_CNT_EN: adds edges_o, a per-channel saturating
// count of tick_o pulses since the channel last entered RUN.
module red_pitaya_clk_gen #(
  parameter int unsigned CHN = 4,
  parameter int unsigned CW  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  red_pitaya_clk_gen_if.slave   cfg
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [CHN-1:0]    clk_vec;
  logic [CHN-1:0]    tick_vec;
  logic [CHN-1:0]    run_vec;
`ifdef RED_PITAYA_CLK_GEN_EDGE_CNT_EN
  logic [CHN*CW-1:0] edges_vec;
`endif

  for (genvar n = 0; n < CHN; n++) begin : g_chn
    logic [CW-1:0] period_w;
    logic [CW-1:0] high_w;
    logic [CW-1:0] phase_w;
    logic [CW-1:0] ld_ps;
    logic [CW-1:0] ld_fs;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] ps_q, ps_d;
    logic [CW-1:0] hs_q, hs_d;
    logic          clk_q, clk_d;
    logic          tick_q, tick_d;
    logic [CW-1:0] ps_m1;
    logic          load;

    assign period_w = cfg.period_i[n*CW +: CW];
    assign high_w   = cfg.high_i[n*CW +: CW];
    assign phase_w  = cfg.phase_i[n*CW +: CW];

    // Load-time clamping: periods below 2 act as 2 and the phase is kept inside the period, which
    // guarantees cnt never exceeds Ps-1 and the increment can never overflow.
    always_comb begin
      ld_ps = (period_w < CW'(2)) ? CW'(2) : period_w;
      ld_fs = (phase_w < ld_ps) ? phase_w : (ld_ps - CW'(1));
    end

    // Wrap point comes from the shadow only, so live config changes cannot move it mid-period.
    assign ps_m1 = ps_q - CW'(1);

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ps_d    = ps_q;
      hs_d    = hs_q;
      clk_d   = clk_q;
      tick_d  = tick_q;
      load    = 1'b0;

      case (state_q)
        StIdle: begin
          cnt_d  = '0;
          clk_d  = 1'b0;
          tick_d = 1'b0;
          if (cfg.en_i[n]) begin
            load    = 1'b1;
            state_d = StRun;
            cnt_d   = ld_fs;
            clk_d   = (ld_fs < high_w);
            tick_d  = (ld_fs == '0);
          end
        end

        StRun: begin
          if (!cfg.en_i[n]) begin
            // Disable truncates whatever phase is in progress.
            state_d = StIdle;
            cnt_d   = '0;
            clk_d   = 1'b0;
            tick_d  = 1'b0;
          end else begin
            // Sync takes precedence over the wrap; both reload, so a sync on a wrap edge is a
            // single reload.
            if (cfg.sync_i) begin
              load  = 1'b1;
              cnt_d = ld_fs;
            end else if (cnt_q == ps_m1) begin
              load  = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
            // A freshly loaded period is judged against the new high time.
            clk_d  = (cnt_d < (load ? high_w : hs_q));
            tick_d = (cnt_d == '0);
          end
        end

        default: begin
          state_d = StIdle;
          cnt_d   = '0;
          clk_d   = 1'b0;
          tick_d  = 1'b0;
        end
      endcase

      // The phase is consumed at load time only, so no shadow copy of it is kept.
      if (load) begin
        ps_d = ld_ps;
        hs_d = high_w;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        ps_q    <= '0;
        hs_q    <= '0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        ps_q    <= ps_d;
        hs_q    <= hs_d;
        clk_q   <= clk_d;
        tick_q  <= tick_d;
      end
    end

    assign clk_vec[n]  = clk_q;
    assign tick_vec[n] = tick_q;
    assign run_vec[n]  = (state_q == StRun);

`ifdef RED_PITAYA_CLK_GEN_EDGE_CNT_EN
    logic [CW-1:0] edges_q, edges_d;

    // Counts registered tick pulses, so the count reflects a tick one cycle after it is shown.
    // The count is held while idle and restarted on entry to RUN.
    always_comb begin
      edges_d = edges_q;
      if (state_q == StIdle) begin
        if (cfg.en_i[n]) begin
          edges_d = '0;
        end
      end else if (tick_q && !(&edges_q)) begin
        edges_d = edges_q + CW'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        edges_q <= '0;
      end else begin
        edges_q <= edges_d;
      end
    end

    assign edges_vec[n*CW +: CW] = edges_q;
`endif
  end

  assign cfg.clk_o   = clk_vec;
  assign cfg.tick_o  = tick_vec;
  assign cfg.run_o   = run_vec;
`ifdef RED_PITAYA_CLK_GEN_EDGE_CNT_EN
  assign cfg.edges_o = edges_vec;
`endif

endmodule

// File: tb/tb_red_pitaya_clk_gen.sv
// Self-checking bench for red_pitaya_clk_gen: directed scenarios followed by random traffic, all
// checked every cycle against a behavioural model of each channel's position within its period.
module tb_red_pitaya_clk_gen;

  localparam int CHN  = 4;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  red_pitaya_clk_gen_if #(.CHN(CHN), .CW(CW)) bus ();

  red_pitaya_clk_gen #(.CHN(CHN), .CW(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .cfg   (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Model: whether the channel runs, where it is inside its period, and the settings it latched.
  int m_run   [CHN];
  int m_pos   [CHN];
  int m_p     [CHN];
  int m_h     [CHN];
  int m_edges [CHN];
  logic [CHN-1:0]    e_clk;
  logic [CHN-1:0]    e_tick;
  logic [CHN-1:0]    e_run;
  logic [CHN*CW-1:0] e_edges;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic latch_cfg(input int ch);
    int p, f;
    p = int'(bus.period_i[ch*CW +: CW]);
    f = int'(bus.phase_i[ch*CW +: CW]);
    if (p < 2) p = 2;
    if (f > p - 1) f = p - 1;
    m_p[ch]   = p;
    m_h[ch]   = int'(bus.high_i[ch*CW +: CW]);
    m_pos[ch] = f;
  endtask

  task automatic model_edge();
    for (int ch = 0; ch < CHN; ch++) begin
      if (rst) begin
        m_run[ch]   = 0;
        m_edges[ch] = 0;
        e_clk[ch]   = 1'b0;
        e_tick[ch]  = 1'b0;
      end else if (m_run[ch] == 0) begin
        e_clk[ch]  = 1'b0;
        e_tick[ch] = 1'b0;
        if (bus.en_i[ch]) begin
          latch_cfg(ch);
          m_run[ch]   = 1;
          m_edges[ch] = 0;
          e_clk[ch]   = (m_pos[ch] < m_h[ch]);
          e_tick[ch]  = (m_pos[ch] == 0);
        end
      end else begin
        if (e_tick[ch] && m_edges[ch] < CMAX) m_edges[ch]++;
        if (!bus.en_i[ch]) begin
          m_run[ch]  = 0;
          e_clk[ch]  = 1'b0;
          e_tick[ch] = 1'b0;
        end else begin
          if (bus.sync_i) latch_cfg(ch);
          else if (m_pos[ch] == m_p[ch] - 1) begin
            latch_cfg(ch);
            m_pos[ch] = 0;
          end else m_pos[ch]++;
          e_clk[ch]  = (m_pos[ch] < m_h[ch]);
          e_tick[ch] = (m_pos[ch] == 0);
        end
      end
      e_run[ch]              = (m_run[ch] != 0);
      e_edges[ch*CW +: CW]   = CW'(m_edges[ch]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("clk_o", 64'(bus.clk_o), 64'(e_clk));
    check("tick_o", 64'(bus.tick_o), 64'(e_tick));
    check("run_o", 64'(bus.run_o), 64'(e_run));
`ifdef RED_PITAYA_CLK_GEN_EDGE_CNT_EN
    check("edges_o", 64'(bus.edges_o), 64'(e_edges));
`endif
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_cfg(input int ch, input int p, input int h, input int f);
    bus.period_i[ch*CW +: CW] = CW'(p);
    bus.high_i[ch*CW +: CW]   = CW'(h);
    bus.phase_i[ch*CW +: CW]  = CW'(f);
  endtask

  // Advance until the model says channel ch sits at count pos; an expired budget is a failure.
  task automatic wait_pos(input int ch, input int pos, input int budget);
    int n;
    n = 0;
    while (!(m_run[ch] != 0 && m_pos[ch] == pos) && n < budget) begin
      step();
      n++;
    end
    if (!(m_run[ch] != 0 && m_pos[ch] == pos)) begin
      compared++;
      mismatched++;
      $display("FAIL wait_pos ch%0d observed=timeout expected=count %0d", ch, pos);
    end
  endtask

  initial begin
    int hi, ticks, first_tick, aligned;

    for (int ch = 0; ch < CHN; ch++) begin
      m_run[ch] = 0; m_pos[ch] = 0; m_p[ch] = 2; m_h[ch] = 0; m_edges[ch] = 0;
    end
    e_clk = '0; e_tick = '0; e_run = '0; e_edges = '0;
    rst = 1'b1;
    bus.en_i = '1;
    bus.sync_i = 1'b0;
    for (int ch = 0; ch < CHN; ch++) set_cfg(ch, 4, 2, 0);

    // Reset dominates an asserted enable.
    @(negedge clk);
    steps(3);
    check("reset_run", 64'(bus.run_o), 64'd0);
    rst = 1'b0;
    step();
    check("first_run", 64'(bus.run_o), 64'hf);

    // Basic divide on ch0 only.
    rst = 1'b1; step(); rst = 1'b0;
    bus.en_i = '0;
    step();
    set_cfg(0, 10, 3, 0);
    bus.en_i[0] = 1'b1;
    hi = 0; ticks = 0; first_tick = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      hi += int'(bus.clk_o[0]);
      if (bus.tick_o[0]) begin
        ticks++;
        if (first_tick == 0) first_tick = i;
      end
    end
    check("div_high_cycles", 64'(hi), 64'd9);
    check("div_ticks", 64'(ticks), 64'd3);
    check("div_first_tick", 64'(first_tick), 64'd1);

    // Boundaries: tiny period, zero high, oversize high, oversize phase.
    bus.en_i = '0; step();
    set_cfg(0, 10, 3, 15);
    set_cfg(1, 0, 1, 0);
    set_cfg(2, 5, 0, 0);
    set_cfg(3, 10, 20, 0);
    bus.en_i = '1;
    step();
    check("phase_clamp_no_tick", 64'(bus.tick_o[0]), 64'd0);
    step();
    check("phase_clamp_tick", 64'(bus.tick_o[0]), 64'd1);
    steps(20);

    // Glitch-free update: new config takes effect only at the wrap.
    bus.en_i = '0; step();
    set_cfg(0, 8, 4, 0);
    bus.en_i[0] = 1'b1;
    wait_pos(0, 2, 20);
    set_cfg(0, 4, 2, 0);
    steps(20);

    // Sync alignment of two channels enabled two cycles apart.
    bus.en_i = '0; step();
    set_cfg(0, 6, 3, 0);
    set_cfg(1, 6, 2, 0);
    bus.en_i[0] = 1'b1;
    steps(2);
    bus.en_i[1] = 1'b1;
    steps(3);
    bus.sync_i = 1'b1;
    step();
    bus.sync_i = 1'b0;
    check("sync_tick", 64'(bus.tick_o[1:0]), 64'h3);
    aligned = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.tick_o[0] == bus.tick_o[1]) aligned++;
    end
    check("sync_aligned", 64'(aligned), 64'd12);
    wait_pos(0, 5, 10);
    bus.sync_i = 1'b1;
    step();
    bus.sync_i = 1'b0;
    check("sync_on_wrap", 64'(bus.tick_o[1:0]), 64'h3);
    steps(8);

    // Disable mid-high, then re-enable.
    bus.en_i = '0; step();
    set_cfg(0, 4, 2, 0);
    bus.en_i[0] = 1'b1;
    steps(6);
    wait_pos(0, 0, 10);
    bus.en_i[0] = 1'b0;
    step();
    check("disable_clk", 64'(bus.clk_o[0]), 64'd0);
    steps(3);
    bus.en_i[0] = 1'b1;
    steps(10);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        set_cfg($urandom_range(0, CHN - 1), $urandom_range(0, 12), $urandom_range(0, 14),
                $urandom_range(0, 14));
      end
      if ($urandom_range(0, 19) == 0) bus.en_i[$urandom_range(0, CHN - 1)] ^= 1'b1;
      bus.sync_i = ($urandom_range(0, 24) == 0);
      rst = ($urandom_range(0, 149) == 0);
      step();
    end
    bus.sync_i = 1'b0;
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/red_pitaya_clk_gen.md
Name: red_pitaya_clk_gen

Overview:
- Multi-channel programmable clock/strobe generator for timing tests and slow peripheral clocks (LED blink, trigger pacing).
- Generalises the fixed 50%-duty divider into CHN independent channels with run-time period, high time, phase offset and enable.
- Adds a global sync that phase-aligns all channels.
- Single clock domain; sits behind the housekeeping register bank, which drives all config inputs.

Parameters:
- CHN, 4: number of independent output channels (1..16).
- CW, 32: width of period/high/phase counters and config fields.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active-high.
- en_i  in  CHN  per-channel enable, level.
- period_i  in  CHN*CW  per-channel period P in clk_i cycles; channel n at bits [n*CW +: CW].
- high_i  in  CHN*CW  per-channel high time H in cycles.
- phase_i  in  CHN*CW  per-channel start count F.
- sync_i  in  1  one-cycle pulse; restarts all running channels at their phase.
- clk_o  out  CHN  divided clock outputs, registered.
- tick_o  out  CHN  one-cycle strobe at each period start, registered.
- run_o  out  CHN  channel in RUN state.

Behaviour:
- Reset (rst_i=1 at a clk_i edge): all channels go to IDLE; clk_o=0, tick_o=0, run_o=0; counters and shadow regs cleared. rst_i dominates en_i and sync_i.
- Each channel has an independent FSM with states IDLE and RUN; run_o reflects the RUN state.
- Shadow regs Ps, Hs, Fs load from period_i/high_i/phase_i only at these edges:
  - IDLE->RUN;
  - counter wrap (cnt==Ps-1);
  - sync_i in RUN.
  - Mid-period config changes never glitch the output.
- Load rules:
  - Ps = max(period_i, 2), so values 0 and 1 act as 2.
  - Fs = phase_i if phase_i < Ps, else Ps-1.
  - Hs = high_i, unclamped.
- IDLE:
  - cnt=0, clk_o=0, tick_o=0.
  - On en_i=1: load shadows, cnt<=Fs, state<=RUN.
  - Same edge: clk_o<=(Fs<Hs); tick_o<=(Fs==0).
- RUN, en_i=1:
  - cnt<=(cnt==Ps-1) ? 0 : cnt+1.
  - clk_o<=(cnt_next<Hs).
  - tick_o<=(cnt_next==0).
  - Output period is exactly Ps cycles, with clk_o high for min(Hs,Ps) cycles.
  - Hs=0: clk_o constantly 0, tick_o still pulses.
  - Hs>=Ps: clk_o constantly 1.
- RUN, en_i=0: next edge goes to IDLE with clk_o=0, tick_o=0 (disable truncates the current high phase).
- sync_i in RUN:
  - Overrides the increment: reload shadows, cnt<=Fs (new value).
  - Outputs are updated from cnt_next=Fs.
  - Channels with equal P and F are cycle-aligned after sync.
  - sync_i is ignored in IDLE.
- Simultaneous events, priority: rst_i > en_i=0 > sync_i > wrap > increment. A sync on a wrap edge is a single reload, not two.
- Latency: config or en_i sampled at edge t is visible on clk_o/tick_o after edge t (one register stage).
- Arithmetic:
  - All compares are unsigned CW-bit.
  - cnt never exceeds Ps-1, so no overflow path exists.
  - Ps-1 is computed from the shadow reg only.
- Legacy /2·DIV divider behaviour: P=2·DIV, H=DIV, F=0.

Optional Feature:
- Macro: RED_PITAYA_CLK_GEN_EDGE_CNT_EN.
- Defined:
  - Adds output edges_o, out, CHN*CW: per-channel count of tick_o pulses since the channel last entered RUN.
  - Cleared on reset and on the IDLE->RUN edge.
  - Increments on each tick_o.
  - Saturates at all-ones and does not wrap.
  - Held (not cleared) when the channel goes to IDLE.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset: assert rst_i 3 cycles with en_i=1 -> clk_o=0, tick_o=0, run_o=0 throughout; first RUN edge one cycle after rst_i falls.
- Basic divide: ch0 P=10, H=3, F=0, en rising at edge t -> clk_o high cycles t+1..t+3, low t+4..t+10, repeating every 10; tick_o at t+1, t+11, t+21.
- Boundaries:
  - P=0 -> period 2, 50% duty with H=1.
  - H=0 -> clk_o stuck 0 with ticks every P.
  - H=20, P=10 -> clk_o stuck 1.
  - F=15, P=10 -> starts at cnt 9, first tick 1 cycle later.
- Glitch-free update: ch0 P=8, H=4; change to P=4, H=2 at cnt=2 -> current period completes as 8 cycles, then 4-cycle periods.
- Sync alignment: ch0 and ch1 P=6, F=0, enabled 2 cycles apart; pulse sync_i -> tick_o[0] and tick_o[1] coincident on the next edge and every 6 cycles thereafter; sync on a wrap edge gives a single tick.
- Disable mid-high plus edge count (macro defined): P=4, H=2, disable at cnt=0 -> clk_o=0 next edge, edges_o holds; re-enable -> edges_o restarts at 0 then 1 on first tick.
